estados_mascota: RTL
====================

# estados_mascota

Parametrised pet-state engine; next generation of the fixed three-LED states block. Holds N need channels. Each channel is a saturating level register that decays on a prescaled time base and is restored by one-cycle action pulses. A mode FSM (ACTIVO / DORMIDO / ENFERMO) changes how the channels evolve. Sits between the button debouncers and the LED/display drivers of the virtual-pet top level.

## Interface
- NUM_ESTADOS, 3: number of need channels (ch0 ánimo, ch1 sueño, ch2 salud).
- NIVEL_W, 3: level width; MAX = 2^NIVEL_W-1.
- TICK_DIV, 50_000_000: clock cycles per time tick (≥2).
- DECAY_TICKS, 5: ticks between level changes of a channel (≥1).
- UMBRAL, 2: alert threshold; LED lit when level ≤ UMBRAL.
- INC, 2: level increase per action pulse.
- SUENO_IDX, 1 / SALUD_IDX, 2: channel roles.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- btn_accion  in  NUM_ESTADOS  one-cycle restore pulses, one per channel.
- dormir  in  1  level request to sleep.
- modo_test  in  1  1 = tick every cycle (prescaler bypassed).
- nivel  out  NUM_ESTADOS*NIVEL_W  packed levels, ch0 in LSBs.
- led  out  NUM_ESTADOS  led[i] = (nivel[i] ≤ UMBRAL).
- estado  out  2  00 ACTIVO, 01 DORMIDO, 10 ENFERMO; 11 never driven.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps. tick = 1 in the cycle where count == TICK_DIV-1. With modo_test=1, the prescaler is held at 0 and tick = 1 every cycle.
- Per-channel decay counter counts 0..DECAY_TICKS-1 on tick. A channel event occurs on the tick where it wraps.
- Channel event in ACTIVO/ENFERMO: level -= 1, saturating at 0.
- Channel event in DORMIDO: channel SUENO_IDX does level += 1 (saturating at MAX). Other channels decrement as normal.
- btn_accion[i] accepted: level += INC, saturating at MAX. That channel's decay counter is cleared to 0. If a channel event coincides, the button wins and the event is dropped.
- Acceptance rules:
  - ACTIVO: all buttons accepted.
  - DORMIDO: all buttons ignored.
  - ENFERMO: only btn_accion[SALUD_IDX] accepted.
- FSM, evaluated on current registered values, priority top-down:
  - any state, level[SALUD_IDX] == 0 → ENFERMO;
  - ENFERMO, level[SALUD_IDX] > UMBRAL → ACTIVO;
  - ACTIVO, dormir == 1 → DORMIDO;
  - DORMIDO, dormir == 0 or level[SUENO_IDX] == MAX → ACTIVO;
  - otherwise hold.
- If dormir is still 1 after a wake on MAX, the FSM re-enters DORMIDO the next cycle. This is intended.
- All arithmetic is done at NIVEL_W+1 bits, then clamped; no wrap-around is ever visible on nivel.

## Timing
- Reset (rst sampled high at a clk edge):
  - nivel = all MAX;
  - prescaler and decay counters = 0;
  - estado = ACTIVO;
  - led = 0.
- rst has priority over every other input. Asserting it mid-operation restores this state on the next edge.
- nivel and estado are registered. led is combinational from registered nivel, so it changes in the same cycle as nivel.
- Action pulse at edge k → nivel updated after edge k.
- Estado change occurs one edge after the level condition becomes visible on nivel.
- Level change period with modo_test=0 is TICK_DIV*DECAY_TICKS cycles. The first change is visible TICK_DIV*DECAY_TICKS edges after reset release.
- Toggling modo_test mid-count: the prescaler restarts from 0. Decay counters are preserved.
- Multiple btn_accion bits in the same cycle are all applied independently.

## Test plan
Benches override parameters to TICK_DIV=4, DECAY_TICKS=2, NIVEL_W=3, UMBRAL=2, INC=2; MAX=7.
1. Reset then idle, modo_test=0 → nivel=7,7,7, led=000, estado=00. Every channel drops by 1 each 8 cycles. After 40 cycles all levels = 2 and led=111.
2. Idle to 56 cycles → all levels = 0, with no underflow at cycle 64. estado=10 one cycle after salud reaches 0.
3. In ENFERMO, pulse btn_accion=3'b001 → ch0 unchanged. Then pulse 3'b100 twice → salud 0→2→4. estado=00 one cycle after salud=4.
4. From reset, let ch1 decay to 3, then dormir=1, modo_test=1 → estado=01. sueño rises 1 per 2 cycles to 7. estado=00 when sueño=7. Buttons pulsed in DORMIDO leave nivel unchanged.
5. At level 6, pulse btn_accion on the same cycle as a decay event → level = 7 (saturated), no decrement. That channel's next decrement occurs a full period later.
6. Assert rst for 1 cycle mid-DORMIDO with mixed levels → next cycle nivel=7,7,7, estado=00, led=000.

Source files
------------

// File: rtl/estados_mascota.sv
// Virtual-pet need engine: N saturating level channels that decay on a prescaled
// time base, are restored by action pulses, and are steered by an ACTIVO/DORMIDO/ENFERMO FSM.
module estados_mascota #(
    parameter int NUM_ESTADOS = 3,
    parameter int NIVEL_W     = 3,
    parameter int TICK_DIV    = 50_000_000,
    parameter int DECAY_TICKS = 5,
    parameter int UMBRAL      = 2,
    parameter int INC         = 2,
    parameter int SUENO_IDX   = 1,
    parameter int SALUD_IDX   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_ESTADOS-1:0]         btn_accion,
    input  logic                           dormir,
    input  logic                           modo_test,
    output logic [NUM_ESTADOS*NIVEL_W-1:0] nivel,
    output logic [NUM_ESTADOS-1:0]         led,
    output logic [1:0]                     estado
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEC_W = $clog2(DECAY_TICKS + 1);
    localparam logic [NIVEL_W:0]   MAX_EXT    = {1'b0, {NIVEL_W{1'b1}}};
    localparam logic [NIVEL_W:0]   UMBRAL_EXT = (NIVEL_W+1)'(UMBRAL);
    localparam logic [NIVEL_W:0]   INC_EXT    = (NIVEL_W+1)'(INC);
    localparam logic [1:0] ST_ACTIVO  = 2'b00;
    localparam logic [1:0] ST_DORMIDO = 2'b01;
    localparam logic [1:0] ST_ENFERMO = 2'b10;

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               tick;
    logic [1:0]         estado_q, estado_d;
    logic [NIVEL_W-1:0] nivel_q [NUM_ESTADOS];
    logic [NIVEL_W-1:0] nivel_d [NUM_ESTADOS];

    // Test mode pins the prescaler at 0 so normal counting restarts cleanly afterwards.
    always_comb begin
        tick  = 1'b0;
        pre_d = pre_q;
        if (modo_test) begin
            tick  = 1'b1;
            pre_d = '0;
        end else if (pre_q == PRE_W'(TICK_DIV - 1)) begin
            tick  = 1'b1;
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_comb begin
        estado_d = estado_q;
        if (nivel_q[SALUD_IDX] == '0) begin
            estado_d = ST_ENFERMO;
        end else begin
            case (estado_q)
                ST_ENFERMO: if ({1'b0, nivel_q[SALUD_IDX]} > UMBRAL_EXT) estado_d = ST_ACTIVO;
                ST_ACTIVO:  if (dormir) estado_d = ST_DORMIDO;
                ST_DORMIDO: if (!dormir || ({1'b0, nivel_q[SUENO_IDX]} == MAX_EXT)) estado_d = ST_ACTIVO;
                default:    estado_d = ST_ACTIVO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            estado_q <= ST_ACTIVO;
        end else begin
            pre_q    <= pre_d;
            estado_q <= estado_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ESTADOS; gi++) begin : g_canal
            localparam bit ES_SUENO = (gi == SUENO_IDX);
            localparam bit ES_SALUD = (gi == SALUD_IDX);
            logic [DEC_W-1:0] dec_q, dec_d;
            logic [NIVEL_W:0] ext, res;
            logic             acepta, evento;

            assign acepta = btn_accion[gi] &&
                            ((estado_q == ST_ACTIVO) || ((estado_q == ST_ENFERMO) && ES_SALUD));
            assign evento = tick && (dec_q == DEC_W'(DECAY_TICKS - 1));
            assign ext    = {1'b0, nivel_q[gi]};

            // A button wins over a coincident decay event and restarts the decay period.
            always_comb begin
                res   = ext;
                dec_d = dec_q;
                if (acepta) begin
                    res   = ext + INC_EXT;
                    dec_d = '0;
                end else begin
                    if (tick) dec_d = evento ? '0 : dec_q + 1'b1;
                    if (evento) begin
                        if ((estado_q == ST_DORMIDO) && ES_SUENO) res = ext + 1'b1;
                        else                                     res = (ext == '0) ? '0 : ext - 1'b1;
                    end
                end
                nivel_d[gi] = (res > MAX_EXT) ? MAX_EXT[NIVEL_W-1:0] : res[NIVEL_W-1:0];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dec_q       <= '0;
                    nivel_q[gi] <= MAX_EXT[NIVEL_W-1:0];
                end else begin
                    dec_q       <= dec_d;
                    nivel_q[gi] <= nivel_d[gi];
                end
            end

            assign nivel[gi*NIVEL_W +: NIVEL_W] = nivel_q[gi];
            assign led[gi] = ({1'b0, nivel_q[gi]} <= UMBRAL_EXT);
        end
    endgenerate

    assign estado = estado_q;
endmodule
